// File: rtl/sparse_chunk_walker.sv
// Sparse chunk read sequencer: walks the sparsemap segment by segment and emits
// the bit index of every set bit, closing segments and the chunk with end strobes.
module sparse_chunk_walker #(
    parameter int MEM_SIZE        = 128,
    parameter int PREFIX_SUM_SIZE = 8
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  logic                                          start_i,
    input  logic                                          abort_i,
    input  logic                                          chunk_ready_i,
    input  logic [PREFIX_SUM_SIZE-1:0]                    rd_sparsemap_i,
    output logic [$clog2(MEM_SIZE/PREFIX_SUM_SIZE)-1:0]   rd_sparsemap_addr_o,
    output logic [$clog2(PREFIX_SUM_SIZE)-1:0]            pri_enc_match_addr_o,
    output logic                                          pri_enc_end_o,
    output logic                                          chunk_end_o,
    output logic                                          out_valid_o,
    input  logic                                          out_ready_i,
    output logic                                          busy_o,
    output logic                                          done_o,
    output logic [$clog2(MEM_SIZE):0]                     elem_cnt_o
);
    localparam int SEG_NUM = MEM_SIZE / PREFIX_SUM_SIZE;
    localparam int AW      = $clog2(SEG_NUM);
    localparam int MW      = $clog2(PREFIX_SUM_SIZE);
    localparam int CW      = $clog2(MEM_SIZE) + 1;

    typedef enum logic [1:0] {IDLE, LOAD, EMIT, DONE} state_t;

    state_t                     state_r;
    logic [PREFIX_SUM_SIZE-1:0] mask_r;
    logic [AW-1:0]              seg_r;
    logic [CW-1:0]              cnt_r;

    logic                       active_s;
    logic                       load_go_s;
    logic                       hs_s;
    logic                       seg_last_s;
    logic                       seg_done_s;
    logic [PREFIX_SUM_SIZE-1:0] mask_next_s;

    function automatic logic [MW-1:0] lowest_set(input logic [PREFIX_SUM_SIZE-1:0] m);
        logic [MW-1:0] idx;
        idx = {MW{1'b0}};
        for (int i = PREFIX_SUM_SIZE - 1; i >= 0; i--) begin
            if (m[i]) begin
                idx = MW'(i);
            end
        end
        return idx;
    endfunction

    // Handshake qualifiers and strobes; abort and a storage stall suppress all progress.
    always_comb begin
        active_s    = !rst_i && !abort_i && chunk_ready_i;
        load_go_s   = active_s && (state_r == LOAD);
        hs_s        = active_s && (state_r == EMIT) && out_ready_i;
        mask_next_s = mask_r & (mask_r - PREFIX_SUM_SIZE'(1));
        seg_last_s  = (seg_r == AW'(SEG_NUM - 1));
        seg_done_s  = (load_go_s && (rd_sparsemap_i == {PREFIX_SUM_SIZE{1'b0}}))
                    || (hs_s && (mask_next_s == {PREFIX_SUM_SIZE{1'b0}}));

        pri_enc_end_o        = seg_done_s;
        chunk_end_o          = (seg_done_s && seg_last_s)
                             || (!rst_i && abort_i && (state_r != IDLE));
        out_valid_o          = active_s && (state_r == EMIT);
        done_o               = !rst_i && !abort_i && (state_r == DONE);
        busy_o               = (state_r != IDLE);
        rd_sparsemap_addr_o  = seg_r;
        pri_enc_match_addr_o = lowest_set(mask_r);
        elem_cnt_o           = cnt_r;
    end

    // Walk sequencer: one LOAD per segment, one EMIT cycle per accepted element.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
            mask_r  <= {PREFIX_SUM_SIZE{1'b0}};
            seg_r   <= {AW{1'b0}};
            cnt_r   <= {CW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_i && chunk_ready_i) begin
                        seg_r   <= {AW{1'b0}};
                        cnt_r   <= {CW{1'b0}};
                        state_r <= LOAD;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LOAD: begin
                    if (abort_i) begin
                        state_r <= IDLE;
                        mask_r  <= {PREFIX_SUM_SIZE{1'b0}};
                    end else if (chunk_ready_i) begin
                        mask_r <= rd_sparsemap_i;
                        if (rd_sparsemap_i != {PREFIX_SUM_SIZE{1'b0}}) begin
                            state_r <= EMIT;
                        end else if (seg_last_s) begin
                            state_r <= DONE;
                        end else begin
                            seg_r <= seg_r + AW'(1);
                        end
                    end else begin
                        state_r <= LOAD;
                    end
                end
                EMIT: begin
                    if (abort_i) begin
                        state_r <= IDLE;
                        mask_r  <= {PREFIX_SUM_SIZE{1'b0}};
                    end else if (hs_s) begin
                        mask_r <= mask_next_s;
                        cnt_r  <= cnt_r + CW'(1);
                        if (mask_next_s != {PREFIX_SUM_SIZE{1'b0}}) begin
                            state_r <= EMIT;
                        end else if (seg_last_s) begin
                            state_r <= DONE;
                        end else begin
                            seg_r   <= seg_r + AW'(1);
                            state_r <= LOAD;
                        end
                    end else begin
                        state_r <= EMIT;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    mask_r  <= {PREFIX_SUM_SIZE{1'b0}};
                end
                default: begin
                    state_r <= IDLE;
                    mask_r  <= {PREFIX_SUM_SIZE{1'b0}};
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sparse_chunk_walker.sv
// Randomized bench for sparse_chunk_walker: a chunk image is expanded into the
// ordered list of (segment, bit) elements and the DUT's strobes are checked against it.
module tb_sparse_chunk_walker;
    localparam int SEG_NUM = 16;

    logic       clk = 1'b0;
    logic       rst, start, abort, chunk_ready, out_ready;
    logic [7:0] rd_sparsemap;
    logic [3:0] rd_addr;
    logic [2:0] match_addr;
    logic       pri_enc_end, chunk_end, out_valid, busy, done;
    logic [7:0] elem_cnt;
    logic [7:0] mem [SEG_NUM];

    int tests_run    = 0;
    int tests_failed = 0;
    int exp_seg[$];
    int exp_bit[$];
    int n_total, n_acc, next_end;
    bit stopped;

    assign rd_sparsemap = mem[rd_addr];

    always #5 clk = ~clk;

    sparse_chunk_walker dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
        .chunk_ready_i(chunk_ready), .rd_sparsemap_i(rd_sparsemap),
        .rd_sparsemap_addr_o(rd_addr), .pri_enc_match_addr_o(match_addr),
        .pri_enc_end_o(pri_enc_end), .chunk_end_o(chunk_end),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .busy_o(busy), .done_o(done), .elem_cnt_o(elem_cnt)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected element stream: every set bit, segment order then lowest bit first.
    task automatic build_model();
        exp_seg.delete();
        exp_bit.delete();
        for (int s = 0; s < SEG_NUM; s++)
            for (int b = 0; b < 8; b++)
                if (mem[s][b]) begin
                    exp_seg.push_back(s);
                    exp_bit.push_back(b);
                end
        n_total  = exp_seg.size();
        n_acc    = 0;
        next_end = 0;
    endtask

    task automatic start_walk();
        chunk_ready = 1'b1;
        start       = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_walk(input int rdy_pct, input int stall_pct, input int stop_seg);
        int  cycles;
        bit  got_end;
        bit  last_of, exp_end;
        cycles  = 0;
        got_end = 1'b0;
        stopped = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            out_ready   = ($urandom_range(99) < rdy_pct);
            chunk_ready = ($urandom_range(99) >= stall_pct);
            @(negedge clk);
            cycles++;
            if (k == 0) begin
                check_val("first_seg_addr", rd_addr, 0);
                check_val("first_elem_cnt", elem_cnt, 0);
            end
            check_val("busy_in_walk", busy, 1);
            check_val("done_in_walk", done, 0);
            if (!chunk_ready) begin
                check_val("stall_valid", out_valid, 0);
                check_val("stall_chunk_end", chunk_end, 0);
            end
            if (out_valid) begin
                if (exp_seg.size() == 0) begin
                    check_val("spurious_valid", out_valid, 0);
                end else begin
                    check_val("seg_addr", rd_addr, exp_seg[0]);
                    check_val("match_addr", match_addr, exp_bit[0]);
                end
                if (stop_seg >= 0 && int'(rd_addr) == stop_seg) begin
                    stopped = 1'b1;
                    return;
                end
            end
            if (chunk_ready) begin
                last_of = (exp_seg.size() == 1) ||
                          (exp_seg.size() > 1 && exp_seg[1] != exp_seg[0]);
                if (out_valid) exp_end = out_ready && last_of;
                else           exp_end = (exp_seg.size() == 0) || (exp_seg[0] != int'(rd_addr));
                check_val("pri_enc_end", pri_enc_end, exp_end);
            end
            check_val("chunk_end", chunk_end, pri_enc_end && (next_end == SEG_NUM - 1));
            if (pri_enc_end) begin
                check_val("end_seg_addr", rd_addr, next_end);
                next_end++;
            end
            if (out_valid && out_ready && exp_seg.size() > 0) begin
                void'(exp_seg.pop_front());
                void'(exp_bit.pop_front());
                n_acc++;
            end
            if (chunk_end) begin
                got_end = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check_val("walk_completed", got_end, 1);
        check_val("end_pulse_count", next_end, SEG_NUM);
        check_val("all_consumed", exp_seg.size(), 0);
        if (rdy_pct == 100 && stall_pct == 0)
            check_val("walk_latency", cycles, SEG_NUM + n_total);
    endtask

    task automatic finish_walk();
        @(posedge clk);
        #1;
        @(negedge clk);
        check_val("done_pulse", done, 1);
        check_val("done_busy", busy, 1);
        check_val("done_chunk_end", chunk_end, 0);
        check_val("done_elem_cnt", elem_cnt, n_total);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_val("idle_done", done, 0);
        check_val("idle_busy", busy, 0);
        check_val("idle_elem_cnt", elem_cnt, n_total);
    endtask

    task automatic full_walk(input int rdy_pct, input int stall_pct);
        build_model();
        start_walk();
        run_walk(rdy_pct, stall_pct, -1);
        finish_walk();
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_addr"}, rd_addr, 0);
        check_val({tag, "_match"}, match_addr, 0);
        check_val({tag, "_pri_end"}, pri_enc_end, 0);
        check_val({tag, "_chunk_end"}, chunk_end, 0);
        check_val({tag, "_valid"}, out_valid, 0);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_done"}, done, 0);
        check_val({tag, "_cnt"}, elem_cnt, 0);
    endtask

    task automatic random_chunk();
        for (int s = 0; s < SEG_NUM; s++)
            mem[s] = ($urandom_range(2) == 0) ? 8'h00 : 8'($urandom & $urandom);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; chunk_ready = 1'b0; out_ready = 1'b0;
        for (int s = 0; s < SEG_NUM; s++) mem[s] = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset");

        // start without storage ready and abort in IDLE are both ignored
        start = 1'b1; chunk_ready = 1'b0; abort = 1'b1;
        #1 check_val("idle_abort_chunk_end", chunk_end, 0);
        @(posedge clk);
        #1 start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check_val("start_not_ready_busy", busy, 0);

        full_walk(100, 0);                              // all-zero chunk
        mem[0] = 8'b1010_0101;
        full_walk(100, 0);                              // 4 elements, 20-cycle walk
        full_walk(60, 0);                               // same chunk with backpressure
        for (int s = 0; s < SEG_NUM; s++) mem[s] = 8'hFF;
        full_walk(100, 0);                              // 128 elements

        // reset while an element is being offered
        random_chunk();
        mem[2] = 8'h3C;
        build_model();
        start_walk();
        run_walk(70, 0, 2);
        check_val("reset_reached_emit", stopped, 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_all_zero("mid_reset");
        repeat (2) @(posedge clk);
        #1 full_walk(80, 10);

        // abort during segment 3 with a competing start
        random_chunk();
        mem[3] = 8'h81;
        build_model();
        start_walk();
        run_walk(60, 10, 3);
        check_val("abort_reached_emit", stopped, 1);
        abort = 1'b1; start = 1'b1;
        #1;
        check_val("abort_chunk_end", chunk_end, 1);
        check_val("abort_valid", out_valid, 0);
        check_val("abort_pri_end", pri_enc_end, 0);
        check_val("abort_done", done, 0);
        @(posedge clk);
        #1 abort = 1'b0; start = 1'b0;
        @(negedge clk);
        check_val("post_abort_busy", busy, 0);
        check_val("post_abort_chunk_end", chunk_end, 0);
        check_val("post_abort_cnt", elem_cnt, n_acc);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_val("abort_start_ignored", busy, 0);
        full_walk(100, 0);

        for (int w = 0; w < 8; w++) begin
            random_chunk();
            full_walk(int'($urandom_range(40, 100)), int'($urandom_range(0, 25)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/sparse_chunk_walker.md
Name: sparse_chunk_walker

Overview:
- Sequencer for the sparse data-chunk read path: walks the chunk's sparsemap one PREFIX_SUM_SIZE-bit segment at a time.
- For each segment it emits the bit index of every set bit, lowest first, as the priority-encoder match address. It closes each segment with a pri_enc_end pulse and closes the chunk with a chunk_end pulse.
- It sits between the compute-side consumer (valid/ready) and the chunk storage/prefix-sum datapath, which it drives through the sparsemap-address, match-address and end strobes.

Parameters:
- MEM_SIZE, 128, chunk capacity in bytes; must be a multiple of PREFIX_SUM_SIZE.
- PREFIX_SUM_SIZE, 8, sparsemap segment width in bits; power of two.
- SEG_NUM, MEM_SIZE/PREFIX_SUM_SIZE, derived local parameter, not overridable.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  begin a chunk walk; honoured only in IDLE with chunk_ready_i=1
- abort_i  in  1  cancel the walk and return to IDLE
- chunk_ready_i  in  1  chunk storage holds valid data (storage read-ready)
- rd_sparsemap_i  in  PREFIX_SUM_SIZE  segment at rd_sparsemap_addr_o, combinational same-cycle
- rd_sparsemap_addr_o  out  $clog2(SEG_NUM)  current segment index
- pri_enc_match_addr_o  out  $clog2(PREFIX_SUM_SIZE)  bit index of the current element
- pri_enc_end_o  out  1  segment finished; datapath adds the segment popcount to its base
- chunk_end_o  out  1  chunk finished or aborted; datapath clears its base
- out_valid_o  out  1  match address valid; storage read data is valid
- out_ready_i  in  1  consumer accepts the element
- busy_o  out  1  walk in progress (state is not IDLE)
- done_o  out  1  one-cycle pulse after a completed walk
- elem_cnt_o  out  $clog2(MEM_SIZE)+1  elements accepted in the current/last walk

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - State is IDLE; the mask register, segment index and elem_cnt_o are 0.
  - Every output is 0.
  - Reset overrides abort_i and start_i.
- FSM states: IDLE, LOAD, EMIT, DONE.
- IDLE:
  - start_i & chunk_ready_i: segment index <= 0, elem_cnt <= 0, go to LOAD.
  - start_i while not IDLE, or with chunk_ready_i=0, is ignored.
- LOAD (one cycle per segment):
  - mask <= rd_sparsemap_i.
  - If rd_sparsemap_i == 0: assert pri_enc_end_o this cycle. If the segment index is SEG_NUM-1, also assert chunk_end_o and go to DONE. Otherwise increment the segment index and stay in LOAD.
  - If rd_sparsemap_i != 0: go to EMIT with the segment index unchanged.
- EMIT:
  - pri_enc_match_addr_o = index of the lowest set bit of mask; out_valid_o = 1.
  - On out_ready_i: clear that bit and increment elem_cnt.
  - If it was the last set bit: assert pri_enc_end_o in the same cycle as the handshake, while the address still points at the finished segment. Then either (last segment) assert chunk_end_o and go to DONE, or increment the segment index and go to LOAD.
  - While out_ready_i=0: match address and valid hold stable and no strobe is asserted.
- DONE: done_o = 1 for one cycle, then go to IDLE. elem_cnt_o holds until the next start.
- Stall: if chunk_ready_i=0 in LOAD or EMIT, the state holds, out_valid_o=0, and no strobes or handshake occur.
- abort_i in LOAD, EMIT or DONE:
  - chunk_end_o = 1 that cycle; pri_enc_end_o, out_valid_o and done_o are 0.
  - Go to IDLE; the mask is cleared; elem_cnt_o holds.
  - abort_i in IDLE has no effect.
- Strobe rules:
  - pri_enc_end_o is pulsed exactly once per segment visited, i.e. SEG_NUM times per completed walk.
  - chunk_end_o is asserted only together with the final pri_enc_end_o, or on abort.
- Latency: a completed walk takes SEG_NUM + N cycles from LOAD entry to DONE entry (N = nonzero count, no backpressure). done_o occurs in the cycle after chunk_end_o.
- Output drive: rd_sparsemap_addr_o and all strobes are combinational from registered state plus the ready/abort inputs. The sparsemap path has no added pipeline.

Test Plan:
- Reset mid-EMIT with out_valid_o=1 -> next cycle all outputs 0, state IDLE; a start 2 cycles later begins at segment 0.
- All-zero chunk, start_i pulse -> 16 LOAD cycles, 16 pri_enc_end_o pulses, chunk_end_o on the 16th, done_o on the 17th, elem_cnt_o=0, out_valid_o never 1.
- Segment 0 = 8'b1010_0101, rest zero, out_ready_i=1 -> match addresses 0,2,5,7 on 4 consecutive cycles, pri_enc_end_o with index 7, then 15 empty LOADs; elem_cnt_o=4; done at cycle 21.
- Same chunk, out_ready_i low for 3 cycles while the address is 2 -> address 2 and valid held stable, no strobe; then 5 and 7 follow; total 3 cycles longer.
- All 0xFF chunk -> 128 handshakes, addresses cycling 0..7 per segment, segment addresses 0..15, chunk_end_o on handshake 128; elem_cnt_o=128 (8-bit counter does not overflow).
- abort_i in EMIT of segment 3, with start_i asserted the same cycle -> chunk_end_o=1 that cycle only, IDLE next cycle, busy_o=0; start ignored; a later start restarts at segment 0 with elem_cnt_o=0.
